// File: rtl/iter_divider.sv
// Iterative restoring divider: one quotient bit per cycle, {quotient, remainder} out.
// Signed DIV support is built only when ITER_DIVIDER_SIGNED_EN is defined.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE, RUN, FIX, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               b_zero;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH:0]     shifted, diff;

  assign accept  = start && !abort;
  assign b_zero  = (b == '0);
  assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

`ifdef ITER_DIVIDER_SIGNED_EN
  logic sa, sb;
  logic nq_q, nq_d;
  logic nr_q, nr_d;

  assign sa    = is_signed & a[WIDTH-1];
  assign sb    = is_signed & b[WIDTH-1];
  assign op_a  = sa ? -a : a;
  assign op_b  = sb ? -b : b;
  // truncating division: remainder follows the dividend's sign
  assign q_fix = nq_q ? -dvd_q : dvd_q;
  assign r_fix = nr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    nq_d = nq_q;
    nr_d = nr_q;
    if (state_q == IDLE && accept) begin
      nq_d = sa ^ sb;
      nr_d = sa;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nq_q <= 1'b0;
      nr_q <= 1'b0;
    end else begin
      nq_q <= nq_d;
      nr_q <= nr_d;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = is_signed;
  assign op_a        = a;
  assign op_b        = b;
  assign q_fix       = dvd_q;
  assign r_fix       = rem_q[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = b_zero ? FIX : RUN;
      RUN: begin
        if (abort)                  state_d = IDLE;
        else if (cnt_q == CW'(1))   state_d = FIX;
      end
      FIX:  state_d = abort ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    dz_d  = dz_q;
    res_d = res_q;
    dbz_d = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CW'(WIDTH);
          rem_d = '0;
          dvs_d = op_b;
          dz_d  = b_zero;
          // divide-by-zero returns the raw dividend as remainder
          dvd_d = b_zero ? a : op_a;
        end
      end
      RUN: begin
        rem_d = diff[WIDTH] ? shifted : diff;
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        if (!abort) begin
          res_d = dz_q ? {{WIDTH{1'b1}}, dvd_q} : {q_fix, r_fix};
          dbz_d = dz_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN) || (state_q == FIX);
    done        = (state_q == DONE);
    div_by_zero = dbz_q;
    result      = res_q;
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: arithmetic, latency, abort, reset.
// Expectations follow ITER_DIVIDER_SIGNED_EN when it is defined.
module tb_iter_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] result;

  int n_tests;
  int n_fail;

  iter_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. lat = edges from start to done (0 = none).
  task automatic run_op(input bit pre_wait, input logic sg,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int pulse_at, input int abort_at,
                        output int lat, output int bcnt,
                        output logic bdone, output logic babort);
    if (pre_wait) @(negedge clk);
    start = 1'b1;
    is_signed = sg;
    a = av;
    b = bv;
    lat = 0;
    bcnt = 0;
    bdone = 1'b0;
    babort = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        bdone = busy;
        break;
      end
      if (busy) bcnt++;
      if (n == abort_at + 1) babort = busy;
      start = (n == pulse_at);
      a = (n == pulse_at) ? 32'd9 : 32'hDEAD_BEEF;
      b = (n == pulse_at) ? 32'd3 : 32'h0000_0000;
      abort = (n == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int          lat, bcnt;
  logic        bdone, babort;
  logic [63:0] exp_neg, exp_ovf;

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
`ifdef ITER_DIVIDER_SIGNED_EN
    exp_neg = 64'hFFFF_FFFD_FFFF_FFFF;
    exp_ovf = 64'h8000_0000_0000_0000;
`else
    exp_neg = 64'h7FFF_FFFC_0000_0001;
    exp_ovf = 64'h0000_0000_8000_0000;
`endif
    repeat (3) @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    run_op(1'b1, 1'b0, 32'd100, 32'd7, 0, -5, lat, bcnt, bdone, babort);
    chk("u100_7_res", result, 64'h0000_000E_0000_0002);
    chk("u100_7_dbz", 64'(div_by_zero), 64'd0);
    chk("u100_7_lat", 64'(lat), 64'd34);
    chk("u100_7_busy", 64'(bcnt), 64'd33);
    chk("u100_7_busy_done", 64'(bdone), 64'd0);

    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, -5, lat, bcnt, bdone, babort);
    chk("s_m7_2_res", result, exp_neg);
    chk("s_m7_2_lat", 64'(lat), 64'd34);

    run_op(1'b1, 1'b0, 32'd5, 32'd0, 0, -5, lat, bcnt, bdone, babort);
    chk("dz_res", result, 64'hFFFF_FFFF_0000_0005);
    chk("dz_flag", 64'(div_by_zero), 64'd1);
    chk("dz_lat", 64'(lat), 64'd2);

    run_op(1'b1, 1'b0, 32'd8, 32'd2, 0, -5, lat, bcnt, bdone, babort);
    chk("u8_2_res", result, 64'h0000_0004_0000_0000);
    chk("u8_2_dbz", 64'(div_by_zero), 64'd0);

    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -5,
           lat, bcnt, bdone, babort);
    chk("ovf_res", result, exp_ovf);
    chk("ovf_dbz", 64'(div_by_zero), 64'd0);

    run_op(1'b1, 1'b0, 32'd1000, 32'd10, 10, -5, lat, bcnt, bdone, babort);
    chk("busy_start_res", result, 64'h0000_0064_0000_0000);
    chk("busy_start_lat", 64'(lat), 64'd34);
    @(negedge clk);
    chk("busy_start_noq", 64'(busy), 64'd0);

    run_op(1'b1, 1'b0, 32'd77, 32'd5, 0, 20, lat, bcnt, bdone, babort);
    chk("abort_nodone", 64'(lat), 64'd0);
    chk("abort_idle", 64'(babort), 64'd0);
    chk("abort_res", result, 64'h0000_0064_0000_0000);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);

    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b0;
    a = 32'd50;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", result, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0, -5, lat, bcnt, bdone, babort);
    chk("post_rst_res", result, 64'h0000_000E_0000_0002);
    chk("post_rst_lat", 64'(lat), 64'd34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
# iter_divider

- Multi-cycle iterative restoring divider that produces quotient and remainder.
- Feeds the HI/LO path alongside the single-cycle ALU, which deliberately omits division for area.
- Accepts operands on a start pulse, runs one quotient bit per cycle, and returns a 64-bit packed result on a one-cycle done strobe.
- Result packing: `result[63:32]` = quotient, `result[31:0]` = remainder.

## Interface

Parameters:

- `WIDTH`, 32, operand width; `result` is 2*WIDTH bits.

Ports (name, direction, width, meaning):

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `abort` input 1: synchronous cancel of an in-flight operation.
- `is_signed` input 1: 1 = DIV, 0 = DIVU; captured with `start`.
- `a` input WIDTH: dividend; captured with `start`.
- `b` input WIDTH: divisor; captured with `start`.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: one-cycle strobe; `result` is valid.
- `div_by_zero` output 1: valid with `done`; held until the next accepted start.
- `result` output 2*WIDTH: {quotient, remainder}; held until the next accepted start.

## Operation

States:

- IDLE
  - On `start`: capture operands and sign info; take |a| and |b| when signed; clear the remainder accumulator; load iteration counter = WIDTH.
  - b == 0: go to FIX.
  - Otherwise: go to RUN.
- RUN
  - Each cycle: shift {rem, dividend} left by 1, then trial-subtract the divisor.
  - Non-negative difference: keep it and set the quotient bit to 1.
  - Otherwise: restore and set the quotient bit to 0.
  - Decrement the counter; after WIDTH iterations, go to FIX.
- FIX
  - Apply signs.
  - Quotient is negated when sign(a) XOR sign(b).
  - Remainder is negated when sign(a); truncating division, remainder takes the dividend's sign.
  - Write `result`; go to DONE.
- DONE
  - `done` = 1 for exactly this cycle; next state IDLE.
  - A `start` in DONE is ignored.

Arithmetic:

- Internal remainder register is WIDTH+1 bits so the trial subtract does not lose its carry.
- Divide by zero:
  - quotient = all ones;
  - remainder = `a` (raw input, no sign processing);
  - `div_by_zero` = 1.
- Signed overflow, most-negative / -1:
  - quotient = 0x80000000 (the natural result of abs/negate arithmetic);
  - remainder = 0;
  - no flag.

Boundary rules:

- `start` while busy: ignored; no queueing.
- `abort` in RUN or FIX: return to IDLE next cycle.
  - No `done` strobe.
  - `result` and `div_by_zero` keep their previous values.
- `abort` and `start` together in IDLE: `abort` wins; the request is dropped.
- Operand inputs may change freely after the start cycle.

## Timing

Reset values:

- State = IDLE.
- `busy` = 0, `done` = 0, `div_by_zero` = 0, `result` = 0.

Latency, with `start` sampled at edge E0:

- Normal operation:
  - RUN spans E1..E(WIDTH).
  - FIX runs after E(WIDTH); `result` is registered at E(WIDTH+1).
  - `done` is high in the cycle after E(WIDTH+1).
  - Total 34 cycles for WIDTH = 32.
- Divide by zero:
  - FIX after E0, `done` high after E1.
  - Total 2 cycles.

Other timing rules:

- `busy` is high from the cycle after E0 until the cycle `done` is high, in which `busy` = 0.
- Back-to-back throughput: a new `start` is accepted in the cycle after DONE, so one op per WIDTH+3 cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).
  - No `done` is generated.
  - A new `start` is accepted on the first edge after deassertion.

## Configuration

- Macro: `ITER_DIVIDER_SIGNED_EN`.
- Defined:
  - `is_signed` is honoured; abs-value preprocessing and FIX-state negation are present.
- Undefined:
  - `is_signed` is ignored; every operation is unsigned.
  - The negation and abs logic is not synthesised.
  - FIX only registers the result; latency is unchanged.

## Test plan

- Unsigned 100 / 7: `result` = {0x0000000E, 0x00000002}, `div_by_zero` = 0, `done` exactly 34 cycles after start, `busy` high the 33 cycles before.
- Signed -7 / 2 (0xFFFFFFF9, 0x2): `result` = {0xFFFFFFFD, 0xFFFFFFFF}. With the macro undefined, the same stimulus gives {0x7FFFFFFC, 0x00000001}.
- Divide by zero, 5 / 0: `done` 2 cycles after start, `result` = {0xFFFFFFFF, 0x00000005}, `div_by_zero` = 1. Next 8 / 2 clears the flag and returns {4, 0}.
- Signed 0x80000000 / 0xFFFFFFFF: `result` = {0x80000000, 0x00000000}, `div_by_zero` = 0.
- `start` pulsed with new operands at cycle 10 of an op: ignored, first op's result unchanged. `abort` at cycle 20 of a following op: no `done`, prior `result` retained, IDLE next cycle.
- `rst_n` low at cycle 15 of an op: outputs zero immediately, no `done`. `start` after release completes normally in 34 cycles.
